mem_bus_arbiter: RTL and testbench

// Shares the single main-memory port between the I-cache (refill only) and the D-cache (refill and write-back).

---
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Purpose : shares one main-memory port between I-cache refills and D-cache refills/write-backs.
//           Ports: CLK/RESET; I_* and D_* requester ports; MEM_* memory port (strobes, address, write data registered).
// Latency : request seen at edge N -> MEM strobe after N -> requester BUSYWAIT low one cycle after completion.
// Backpr. : MEM_BUSYWAIT holds SERVE; losing/pending requester sees BUSYWAIT=1 until its RELEASE cycle.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 128,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RELEASE_I, RELEASE_D} state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam logic RR_EN = (ROUND_ROBIN != 0);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic i_req;
  logic d_req;
  logic pick_d;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  // D wins when alone, when fixed priority is selected, or when I was served last.
  assign pick_d = d_req & (~i_req | ~RR_EN | (last_grant_q == GNT_I));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = SERVE_D;
          mem_addr_d  = D_ADDRESS;
          mem_wdata_d = D_WRITEDATA;
          // a write-back takes precedence over a refill raised at the same time
          mem_write_d = D_WRITE;
          mem_read_d  = ~D_WRITE;
        end else if (i_req) begin
          state_d     = SERVE_I;
          mem_addr_d  = I_ADDRESS;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
        end
      end

      // The entry edge came from IDLE, so MEM_BUSYWAIT is only looked at from the
      // first edge after entry onwards: at least one cycle is spent here.
      SERVE_I: begin
        if (!MEM_BUSYWAIT) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          // a withdrawn request lets memory finish but the data is dropped
          if (I_READ) begin
            i_rdata_d = MEM_READDATA;
          end
          last_grant_d = GNT_I;
          state_d      = RELEASE_I;
        end
      end

      SERVE_D: begin
        if (!MEM_BUSYWAIT) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q && D_READ) begin
            d_rdata_d = MEM_READDATA;
          end
          last_grant_d = GNT_D;
          state_d      = RELEASE_D;
        end
      end

      RELEASE_I, RELEASE_D: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Stall is dropped only in the requester's own RELEASE cycle.
  assign I_BUSYWAIT    = i_req & (state_q != RELEASE_I);
  assign D_BUSYWAIT    = d_req & (state_q != RELEASE_D);
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : self-checking bench for mem_bus_arbiter (round-robin and fixed-priority instances).
// Latency : memory model stalls a configurable number of cycles per access.
// Backpr. : requesters hold requests until their BUSYWAIT drops.
module tb_mem_bus_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [DW-1:0] D_WRITEDATA = '0;

  logic [DW-1:0] mem_rdata = '0;
  logic          by_addr = 1'b0;
  int            mem_lat = 0;

  // round-robin instance
  logic [DW-1:0] r_I_READDATA, r_D_READDATA, r_MEM_WRITEDATA, r_MEM_READDATA;
  logic          r_I_BUSYWAIT, r_D_BUSYWAIT, r_MEM_READ, r_MEM_WRITE;
  logic [AW-1:0] r_MEM_ADDRESS;
  logic          r_busy = 1'b0;
  int            r_cnt = 0;

  // fixed-priority instance
  logic [DW-1:0] f_I_READDATA, f_D_READDATA, f_MEM_WRITEDATA, f_MEM_READDATA;
  logic          f_I_BUSYWAIT, f_D_BUSYWAIT, f_MEM_READ, f_MEM_WRITE;
  logic [AW-1:0] f_MEM_ADDRESS;
  logic          f_busy = 1'b0;
  int            f_cnt = 0;

  int total = 0;
  int bad   = 0;

  logic          snapped;
  logic          snap_rd, snap_wr;
  logic [AW-1:0] snap_addr;
  logic [DW-1:0] snap_wdata;

  assign r_MEM_READDATA = by_addr ? {4{4'hC, r_MEM_ADDRESS}} : mem_rdata;
  assign f_MEM_READDATA = by_addr ? {4{4'hC, f_MEM_ADDRESS}} : mem_rdata;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) u_rr (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(r_I_READDATA), .I_BUSYWAIT(r_I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(r_D_READDATA), .D_BUSYWAIT(r_D_BUSYWAIT),
    .MEM_READ(r_MEM_READ), .MEM_WRITE(r_MEM_WRITE), .MEM_ADDRESS(r_MEM_ADDRESS),
    .MEM_WRITEDATA(r_MEM_WRITEDATA), .MEM_READDATA(r_MEM_READDATA), .MEM_BUSYWAIT(r_busy)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) u_fix (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(f_I_READDATA), .I_BUSYWAIT(f_I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(f_D_READDATA), .D_BUSYWAIT(f_D_BUSYWAIT),
    .MEM_READ(f_MEM_READ), .MEM_WRITE(f_MEM_WRITE), .MEM_ADDRESS(f_MEM_ADDRESS),
    .MEM_WRITEDATA(f_MEM_WRITEDATA), .MEM_READDATA(f_MEM_READDATA), .MEM_BUSYWAIT(f_busy)
  );

  always #5 CLK = ~CLK;

  // Memory models: busy for mem_lat cycles after a strobe is first seen.
  always @(posedge CLK) begin
    #1;
    if (r_MEM_READ || r_MEM_WRITE) begin
      if (r_cnt < mem_lat) begin r_busy = 1'b1; r_cnt++; end
      else r_busy = 1'b0;
    end else begin
      r_busy = 1'b0; r_cnt = 0;
    end
  end

  always @(posedge CLK) begin
    #1;
    if (f_MEM_READ || f_MEM_WRITE) begin
      if (f_cnt < mem_lat) begin f_busy = 1'b1; f_cnt++; end
      else f_busy = 1'b0;
    end else begin
      f_busy = 1'b0; f_cnt = 0;
    end
  end

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the round-robin instance; returns strobe-high and stalled cycle counts.
  task automatic txn(input bit use_d, input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, output int strobe_n, output int wait_n);
    bit done;
    bit bw;
    @(posedge CLK); #1;
    if (use_d) begin D_READ = rd; D_WRITE = wr; D_ADDRESS = a; D_WRITEDATA = wd; end
    else begin I_READ = 1'b1; I_ADDRESS = a; end
    strobe_n = 0; wait_n = 0; done = 1'b0; snapped = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge CLK);
      if (r_MEM_READ || r_MEM_WRITE) begin
        strobe_n++;
        if (!snapped) begin
          snapped = 1'b1; snap_rd = r_MEM_READ; snap_wr = r_MEM_WRITE;
          snap_addr = r_MEM_ADDRESS; snap_wdata = r_MEM_WRITEDATA;
        end
      end
      bw = use_d ? r_D_BUSYWAIT : r_I_BUSYWAIT;
      if (bw) wait_n++;
      else done = 1'b1;
    end
    check_val("release_seen", done, 1);
    // request still high in the following IDLE cycle: the stall must be back
    @(negedge CLK);
    bw = use_d ? r_D_BUSYWAIT : r_I_BUSYWAIT;
    check_val("bw_after_release", bw, 1);
    #1;
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int sn, wn;
    int d_rel, i_rel;
    int rn, fn;
    logic [3:0] rseq, fseq;
    logic [DW-1:0] a5, dead, wdat;
    a5   = {16{8'hA5}};
    dead = {4{32'hDEADBEEF}};
    wdat = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

    // reset state
    repeat (2) @(negedge CLK);
    check_val("rst_mem_read", r_MEM_READ, 0);
    check_val("rst_mem_write", r_MEM_WRITE, 0);
    check_val("rst_mem_addr", r_MEM_ADDRESS, 0);
    check_val("rst_mem_wdata", r_MEM_WRITEDATA, 0);
    check_val("rst_i_rdata", r_I_READDATA, 0);
    check_val("rst_d_rdata", r_D_READDATA, 0);
    check_val("rst_i_bw", r_I_BUSYWAIT, 0);
    check_val("rst_d_bw", r_D_BUSYWAIT, 0);
    RESET = 1'b1;

    // I refill, memory busy 5 cycles
    mem_lat = 5; mem_rdata = a5;
    txn(1'b0, 1'b1, 1'b0, 28'h0000010, '0, sn, wn);
    check_val("i_strobe_cycles", sn, 6);
    check_val("i_wait_cycles", wn, 7);
    check_val("i_rdata", r_I_READDATA, a5);
    check_val("i_snap_rd", snap_rd, 1);
    check_val("i_snap_wr", snap_wr, 0);
    check_val("i_snap_addr", snap_addr, 28'h10);

    // D write-back, memory busy 3 cycles
    mem_lat = 3;
    txn(1'b1, 1'b0, 1'b1, 28'h0000020, wdat, sn, wn);
    check_val("dw_strobe_cycles", sn, 4);
    check_val("dw_wait_cycles", wn, 5);
    check_val("dw_snap_wr", snap_wr, 1);
    check_val("dw_snap_rd", snap_rd, 0);
    check_val("dw_snap_addr", snap_addr, 28'h20);
    check_val("dw_snap_wdata", snap_wdata, wdat);
    check_val("dw_d_rdata_kept", r_D_READDATA, 0);

    // D refill, best-case memory
    mem_lat = 0; mem_rdata = dead;
    txn(1'b1, 1'b1, 1'b0, 28'h0000030, '0, sn, wn);
    check_val("dr_strobe_cycles", sn, 1);
    check_val("dr_wait_cycles", wn, 2);
    check_val("dr_snap_rd", snap_rd, 1);
    check_val("dr_d_rdata", r_D_READDATA, dead);

    // D_READ and D_WRITE together: write-back wins
    mem_lat = 1; mem_rdata = a5;
    txn(1'b1, 1'b1, 1'b1, 28'h0000038, wdat, sn, wn);
    check_val("rw_snap_wr", snap_wr, 1);
    check_val("rw_snap_rd", snap_rd, 0);
    check_val("rw_d_rdata_kept", r_D_READDATA, dead);
    check_val("rw_i_rdata_kept", r_I_READDATA, a5);

    // asynchronous reset in the middle of a write-back
    mem_lat = 10;
    @(posedge CLK); #1;
    D_WRITE = 1'b1; D_ADDRESS = 28'h60; D_WRITEDATA = wdat;
    repeat (3) @(negedge CLK);
    check_val("ar_write_before", r_MEM_WRITE, 1);
    #2 RESET = 1'b0;
    #1;
    check_val("ar_write_dropped", r_MEM_WRITE, 0);
    check_val("ar_addr_cleared", r_MEM_ADDRESS, 0);
    check_val("ar_d_rdata", r_D_READDATA, 0);
    check_val("ar_i_rdata", r_I_READDATA, 0);
    D_WRITE = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK);
    check_val("ar_idle_no_strobe", r_MEM_WRITE | r_MEM_READ, 0);

    // simultaneous I and D refills, last_grant=I after reset: D then I
    mem_lat = 2; by_addr = 1'b1;
    I_ADDRESS = 28'h40; D_ADDRESS = 28'h50;
    @(posedge CLK); #1;
    I_READ = 1'b1; D_READ = 1'b1;
    d_rel = -1; i_rel = -1;
    for (int c = 0; c < 60 && (d_rel < 0 || i_rel < 0); c++) begin
      @(negedge CLK);
      if (D_READ && !r_D_BUSYWAIT) d_rel = c;
      if (I_READ && !r_I_BUSYWAIT) i_rel = c;
      if (d_rel == c || i_rel == c) begin
        @(posedge CLK); #1;
        if (d_rel == c) D_READ = 1'b0;
        if (i_rel == c) I_READ = 1'b0;
      end
    end
    check_val("coll_both_done", (d_rel >= 0) && (i_rel >= 0), 1);
    check_val("coll_d_first", d_rel < i_rel, 1);
    check_val("coll_gap", i_rel - d_rel, 5);
    check_val("coll_d_rdata", r_D_READDATA, {4{4'hC, 28'h50}});
    check_val("coll_i_rdata", r_I_READDATA, {4{4'hC, 28'h40}});

    // continuous collisions: round-robin alternates, fixed priority always D
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    mem_lat = 0; I_ADDRESS = 28'h70; D_ADDRESS = 28'h80;
    @(posedge CLK); #1;
    I_READ = 1'b1; D_READ = 1'b1;
    rn = 0; fn = 0; rseq = '0; fseq = '0;
    for (int c = 0; c < 80 && (rn < 4 || fn < 4); c++) begin
      @(negedge CLK);
      if (rn < 4) begin
        if (!r_D_BUSYWAIT) begin rseq = {rseq[2:0], 1'b1}; rn++; end
        else if (!r_I_BUSYWAIT) begin rseq = {rseq[2:0], 1'b0}; rn++; end
      end
      if (fn < 4) begin
        if (!f_D_BUSYWAIT) begin fseq = {fseq[2:0], 1'b1}; fn++; end
        else if (!f_I_BUSYWAIT) begin fseq = {fseq[2:0], 1'b0}; fn++; end
      end
    end
    #1;
    I_READ = 1'b0; D_READ = 1'b0;
    check_val("rr_grant_count", rn, 4);
    check_val("rr_grant_seq", rseq, 4'b1010);
    check_val("fix_grant_count", fn, 4);
    check_val("fix_grant_seq", fseq, 4'b1111);

    // any withdrawn in-flight access still finishes and the port goes quiet
    repeat (6) @(negedge CLK);
    check_val("end_rr_quiet", r_MEM_READ | r_MEM_WRITE, 0);
    check_val("end_fix_quiet", f_MEM_READ | f_MEM_WRITE, 0);
    check_val("end_i_bw", r_I_BUSYWAIT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
